// File: rtl/program_load_controller.sv
// program_load_controller
// Owns the CPU instruction memory. A word loader fills it over a
// valid/ready port while the CPU is held in reset; the controller then
// sequences the CPU through run, halt and single-step by gating its clock
// enable, and counts the cycles the CPU was allowed to advance.
//
// Ports
//   clock, isReset          system clock, async active-high reset
//   loadStart               level request to (re)load a program
//   loadWord/Valid/Last     loader word stream, loadReady is the accept
//   runEnable               level: 1 = free-run, 0 = halt
//   stepRequest             single step on each 0->1 edge while halted
//   pc / instruction        combinational fetch port (zero in IDLE/LOAD)
//   cpuReset                CPU reset, high in IDLE/LOAD/DONE
//   cpuClockEnable          CPU may advance this cycle (RUN/STEP)
//   loadCount, loadError    words written by the load, sticky overflow flag
//   cycleCount              enabled cycles since the last load (saturating)
//   state                   current FSM state
//
// state | meaning
// IDLE  | CPU in reset, waiting for loadStart
// LOAD  | accepting loader words into memory
// DONE  | load complete, one cycle, clears cycleCount
// RUN   | CPU free-running
// HALT  | CPU stopped, state preserved
// STEP  | one enabled cycle, then back to HALT

module program_load_controller #(
  parameter int PC_WIDTH          = 8,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int CYCLE_COUNT_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         isReset,
  input  logic                         loadStart,
  input  logic [INSTRUCTION_WIDTH-1:0] loadWord,
  input  logic                         loadValid,
  input  logic                         loadLast,
  output logic                         loadReady,
  input  logic                         runEnable,
  input  logic                         stepRequest,
  input  logic [PC_WIDTH-1:0]          pc,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         cpuReset,
  output logic                         cpuClockEnable,
  output logic [PC_WIDTH:0]            loadCount,
  output logic                         loadError,
  output logic [CYCLE_COUNT_WIDTH-1:0] cycleCount,
  output logic [2:0]                   state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DONE = 3'd2,
    S_RUN  = 3'd3,
    S_HALT = 3'd4,
    S_STEP = 3'd5
  } state_t;

  localparam int                     DEPTH     = 2 ** PC_WIDTH;
  localparam logic [PC_WIDTH-1:0]    ADDR_LAST = '1;
  localparam logic [PC_WIDTH-1:0]    ADDR_ONE  = PC_WIDTH'(1);
  localparam logic [PC_WIDTH:0]      CNT_ONE   = (PC_WIDTH + 1)'(1);
  localparam logic [CYCLE_COUNT_WIDTH-1:0] CYC_ONE = CYCLE_COUNT_WIDTH'(1);
  localparam logic [CYCLE_COUNT_WIDTH-1:0] CYC_MAX = '1;

  state_t                         r_state;
  logic [PC_WIDTH-1:0]            r_addr;
  logic [PC_WIDTH:0]              r_load_count;
  logic                           r_load_error;
  logic [CYCLE_COUNT_WIDTH-1:0]   r_cycle_count;
  logic                           r_step_d;
  logic                           r_cpu_reset;
  logic                           r_cpu_clock_enable;
  logic                           r_load_ready;
  logic [INSTRUCTION_WIDTH-1:0]   r_mem [DEPTH];

  state_t w_next_state;
  logic   w_accept;
  logic   w_overflow;
  logic   w_step_rise;
  logic   w_load_begin;

  // loadReady is only ever high in LOAD, so it alone qualifies a write.
  assign w_accept     = r_load_ready & loadValid;
  assign w_overflow   = w_accept & ~loadLast & (r_addr == ADDR_LAST);
  assign w_step_rise  = stepRequest & ~r_step_d;
  assign w_load_begin = (w_next_state == S_LOAD) && (r_state != S_LOAD);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (loadStart) w_next_state = S_LOAD;
      S_LOAD: begin
        if (w_accept) begin
          if (loadLast)        w_next_state = S_DONE;
          else if (w_overflow) w_next_state = S_IDLE;
        end
      end
      S_DONE: w_next_state = runEnable ? S_RUN : S_HALT;
      S_RUN: begin
        if (loadStart)       w_next_state = S_LOAD;
        else if (!runEnable) w_next_state = S_HALT;
      end
      S_HALT: begin
        if (loadStart)        w_next_state = S_LOAD;
        else if (runEnable)   w_next_state = S_RUN;
        else if (w_step_rise) w_next_state = S_STEP;
      end
      S_STEP:  w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clock or posedge isReset) begin
    if (isReset) begin
      r_state            <= S_IDLE;
      r_addr             <= '0;
      r_load_count       <= '0;
      r_load_error       <= 1'b0;
      r_cycle_count      <= '0;
      r_step_d           <= 1'b0;
      r_cpu_reset        <= 1'b1;
      r_cpu_clock_enable <= 1'b0;
      r_load_ready       <= 1'b0;
    end else begin
      r_state            <= w_next_state;
      r_step_d           <= stepRequest;
      r_cpu_reset        <= (w_next_state == S_IDLE) || (w_next_state == S_LOAD) ||
                            (w_next_state == S_DONE);
      r_cpu_clock_enable <= (w_next_state == S_RUN) || (w_next_state == S_STEP);
      r_load_ready       <= (w_next_state == S_LOAD);

      if (w_load_begin) begin
        r_addr       <= '0;
        r_load_count <= '0;
        r_load_error <= 1'b0;
      end else if (w_accept) begin
        // No wrap at the top of memory: the overflow word is the last write.
        if (r_addr != ADDR_LAST) r_addr <= r_addr + ADDR_ONE;
        r_load_count <= r_load_count + CNT_ONE;
        if (w_overflow) r_load_error <= 1'b1;
      end

      if (r_state == S_DONE)
        r_cycle_count <= '0;
      else if (r_cpu_clock_enable && (r_cycle_count != CYC_MAX))
        r_cycle_count <= r_cycle_count + CYC_ONE;
    end
  end

  // Memory is deliberately not reset so a reset mid-load keeps earlier words.
  always_ff @(posedge clock) begin
    if (w_accept) r_mem[r_addr] <= loadWord;
  end

  assign instruction    = ((r_state == S_IDLE) || (r_state == S_LOAD)) ? '0 : r_mem[pc];
  assign loadReady      = r_load_ready;
  assign cpuReset       = r_cpu_reset;
  assign cpuClockEnable = r_cpu_clock_enable;
  assign loadCount      = r_load_count;
  assign loadError      = r_load_error;
  assign cycleCount     = r_cycle_count;
  assign state          = r_state;

endmodule

// File: tb/tb_program_load_controller.sv
module tb_program_load_controller;

  localparam int PW = 2;
  localparam int IW = 32;
  localparam int CW = 4;
  localparam int DEPTH = 4;
  localparam int CYC_MAX = 15;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_DONE = 3'd2,
                         ST_RUN = 3'd3, ST_HALT = 3'd4, ST_STEP = 3'd5;

  logic          clock = 1'b0;
  logic          isReset;
  logic          loadStart;
  logic [IW-1:0] loadWord;
  logic          loadValid;
  logic          loadLast;
  logic          loadReady;
  logic          runEnable;
  logic          stepRequest;
  logic [PW-1:0] pc;
  logic [IW-1:0] instruction;
  logic          cpuReset;
  logic          cpuClockEnable;
  logic [PW:0]   loadCount;
  logic          loadError;
  logic [CW-1:0] cycleCount;
  logic [2:0]    state;

  int total = 0;
  int bad   = 0;

  // Reference: what the memory should hold and how many enabled cycles ran.
  logic [IW-1:0] m_mem [DEPTH];
  int            m_cycles;

  program_load_controller #(
    .PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW), .CYCLE_COUNT_WIDTH(CW)
  ) dut (
    .clock(clock), .isReset(isReset), .loadStart(loadStart),
    .loadWord(loadWord), .loadValid(loadValid), .loadLast(loadLast),
    .loadReady(loadReady), .runEnable(runEnable), .stepRequest(stepRequest),
    .pc(pc), .instruction(instruction), .cpuReset(cpuReset),
    .cpuClockEnable(cpuClockEnable), .loadCount(loadCount),
    .loadError(loadError), .cycleCount(cycleCount), .state(state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > CYC_MAX) ? CYC_MAX : a + b;
  endfunction

  task automatic check_fetch_all(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      pc = PW'(a);
      #1;
      check(tag, instruction, m_mem[a]);
    end
  endtask

  // From HALT/IDLE/RUN: load n words with random valid gaps, last on the final word.
  task automatic load_prog(input int n, input int max_gap);
    logic [IW-1:0] w;
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    for (int i = 0; i < n; i++) begin
      loadValid = 1'b0;
      repeat ($urandom_range(max_gap, 0)) tick();
      w = $urandom;
      loadWord  = w;
      loadValid = 1'b1;
      loadLast  = (i == n - 1);
      tick();
      m_mem[i] = w;
    end
    loadValid = 1'b0;
    loadLast  = 1'b0;
  endtask

  initial begin
    int pulses;
    int k;
    int s;
    logic [IW-1:0] w0, w1;

    isReset = 1'b1; loadStart = 0; loadWord = '0; loadValid = 0; loadLast = 0;
    runEnable = 0; stepRequest = 0; pc = '0;
    for (int a = 0; a < DEPTH; a++) m_mem[a] = 'x;
    m_cycles = 0;
    #12;
    check("rst_state", state, ST_IDLE);
    check("rst_cpureset", cpuReset, 1);
    check("rst_cen", cpuClockEnable, 0);
    check("rst_ready", loadReady, 0);
    check("rst_loadcount", loadCount, 0);
    check("rst_loaderror", loadError, 0);
    check("rst_cycles", cycleCount, 0);
    check("rst_instr", instruction, 0);
    isReset = 1'b0;
    tick();

    // Basic load of three words, then free-run.
    runEnable = 1'b1;
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    check("load_state", state, ST_LOAD);
    check("load_ready", loadReady, 1);
    check("load_cpureset", cpuReset, 1);
    for (int i = 0; i < 3; i++) begin
      loadWord  = 32'h11 * (i + 1);
      loadValid = 1'b1;
      loadLast  = (i == 2);
      m_mem[i]  = 32'h11 * (i + 1);
      tick();
    end
    loadValid = 1'b0; loadLast = 1'b0;
    check("done_state", state, ST_DONE);
    check("done_count", loadCount, 3);
    check("done_ready", loadReady, 0);
    check("done_cpureset", cpuReset, 1);
    tick();
    check("run_state", state, ST_RUN);
    check("run_cpureset", cpuReset, 0);
    check("run_cen", cpuClockEnable, 1);
    check("run_cycles0", cycleCount, 0);
    pc = 2'd1;
    #1;
    check("run_fetch_pc1", instruction, 32'h22);
    repeat (10) tick();
    check("run_cycles10", cycleCount, 10);

    // Reload from RUN: loadStart wins over runEnable.
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    check("reload_state", state, ST_LOAD);
    check("reload_cpureset", cpuReset, 1);
    check("reload_cen", cpuClockEnable, 0);

    // Throttled loader: valid 1,0,1,0 for two words.
    loadWord = 32'hA0A0_0001; loadValid = 1'b1; m_mem[0] = 32'hA0A0_0001;
    tick();
    check("thr_count1", loadCount, 1);
    loadValid = 1'b0;
    tick();
    check("thr_hold", loadCount, 1);
    loadWord = 32'hB0B0_0002; loadValid = 1'b1; loadLast = 1'b1; m_mem[1] = 32'hB0B0_0002;
    runEnable = 1'b0;
    tick();
    loadValid = 1'b0; loadLast = 1'b0;
    check("thr_done", state, ST_DONE);
    check("thr_count2", loadCount, 2);
    tick();
    check("thr_halt", state, ST_HALT);
    check("thr_cycles_clr", cycleCount, 0);
    check("halt_cpureset", cpuReset, 0);
    check("halt_cen", cpuClockEnable, 0);
    m_cycles = 0;
    check_fetch_all("thr_fetch");

    // Held step request gives exactly one step.
    stepRequest = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses += int'(cpuClockEnable);
    end
    check("step_pulses", pulses, 1);
    m_cycles = sat_add(m_cycles, 1);
    check("step_cycles1", cycleCount, m_cycles);
    check("step_back_halt", state, ST_HALT);
    stepRequest = 1'b0;
    tick();
    stepRequest = 1'b1;
    tick();
    check("step2_state", state, ST_STEP);
    check("step2_cen", cpuClockEnable, 1);
    tick();
    m_cycles = sat_add(m_cycles, 1);
    check("step2_cycles", cycleCount, m_cycles);
    stepRequest = 1'b0;

    // Saturation of the cycle counter.
    runEnable = 1'b1;
    tick();
    repeat (20) tick();
    runEnable = 1'b0;
    tick();
    m_cycles = sat_add(m_cycles, 21);
    check("sat_state", state, ST_HALT);
    check("sat_cycles", cycleCount, m_cycles);

    // Overflow: four words, no last.
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      loadWord = $urandom; m_mem[i] = loadWord; loadValid = 1'b1;
      tick();
    end
    loadValid = 1'b0;
    check("ovf_state", state, ST_IDLE);
    check("ovf_error", loadError, 1);
    check("ovf_count", loadCount, 4);
    check("ovf_cpureset", cpuReset, 1);
    check("ovf_ready", loadReady, 0);
    tick();
    check("ovf_sticky", loadError, 1);
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
    check("ovf_clear", loadError, 0);
    check("ovf_reload", state, ST_LOAD);

    // Async reset mid-load keeps the words already written.
    w0 = $urandom; w1 = $urandom;
    loadWord = w0; loadValid = 1'b1; tick();
    loadWord = w1; tick();
    loadValid = 1'b0;
    m_mem[0] = w0; m_mem[1] = w1;
    #2 isReset = 1'b1;
    #1;
    check("mid_rst_state", state, ST_IDLE);
    check("mid_rst_ready", loadReady, 0);
    check("mid_rst_count", loadCount, 0);
    check("mid_rst_cpureset", cpuReset, 1);
    #1 isReset = 1'b0;
    tick();
    load_prog(1, 0);
    tick();
    check("mid_rst_halt", state, ST_HALT);
    m_cycles = 0;
    check_fetch_all("mid_rst_fetch");

    // Randomized programs, run lengths and step counts.
    for (int it = 0; it < 6; it++) begin
      k = $urandom_range(4, 1);
      load_prog(k, 2);
      check("rnd_done", state, ST_DONE);
      check("rnd_count", loadCount, k);
      tick();
      m_cycles = 0;
      check("rnd_halt", state, ST_HALT);
      check_fetch_all("rnd_fetch");
      k = $urandom_range(20, 1);
      runEnable = 1'b1;
      repeat (k) tick();
      runEnable = 1'b0;
      tick();
      m_cycles = sat_add(m_cycles, k);
      check("rnd_run_halt", state, ST_HALT);
      check("rnd_run_cycles", cycleCount, m_cycles);
      s = $urandom_range(3, 0);
      for (int j = 0; j < s; j++) begin
        stepRequest = 1'b1;
        repeat ($urandom_range(4, 2)) tick();
        stepRequest = 1'b0;
        tick();
      end
      m_cycles = sat_add(m_cycles, s);
      check("rnd_step_cycles", cycleCount, m_cycles);
      pc = PW'($urandom_range(DEPTH - 1, 0));
      #1;
      check("rnd_fetch_pc", instruction, m_mem[pc]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
